// File: rtl/load_store_unit.sv
// load_store_unit
// ---------------
// Bridges execute and data memory and owns the register file write port.
// One load/store request is accepted at a time over a valid/ready handshake.
// Each request is turned into a word-aligned memory access with byte enables;
// loads are sign- or zero-extended and written back in a single WB cycle.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   req_valid / req_ready      request handshake from execute
//   req_is_store, req_funct3   access kind and RV32I width code
//   req_addr, req_wdata        byte address and right-aligned store data
//   req_rd                     load destination register
//   mem_valid / mem_ready      memory request handshake
//   mem_we, mem_addr           write flag and word address
//   mem_wdata, mem_be          lane-replicated store data and byte enables
//   mem_rvalid, mem_rdata      read data return
//   WE3, AD3, WD3              register file write port
//   busy                       high whenever the unit is not idle
//   err                        one-cycle pulse on misaligned/illegal request
module load_store_unit #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_is_store,
   input  logic [2:0]               req_funct3,
   input  logic [DATA_WIDTH-1:0]    req_addr,
   input  logic [DATA_WIDTH-1:0]    req_wdata,
   input  logic [ADDRESS_WIDTH-1:0] req_rd,
   output logic                     mem_valid,
   input  logic                     mem_ready,
   output logic                     mem_we,
   output logic [DATA_WIDTH-1:0]    mem_addr,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   output logic [3:0]               mem_be,
   input  logic                     mem_rvalid,
   input  logic [DATA_WIDTH-1:0]    mem_rdata,
   output logic                     WE3,
   output logic [ADDRESS_WIDTH-1:0] AD3,
   output logic [DATA_WIDTH-1:0]    WD3,
   output logic                     busy,
   output logic                     err
);

   typedef enum logic [2:0] {IDLE, ERR, REQ, WAIT, WB} state_t;

   state_t                   state_reg, state_next;
   logic                     is_store_reg;
   logic [2:0]               funct3_reg;
   logic [DATA_WIDTH-1:0]    addr_reg;
   logic [DATA_WIDTH-1:0]    wdata_reg;
   logic [DATA_WIDTH-1:0]    rdata_reg;
   logic [ADDRESS_WIDTH-1:0] rd_reg;

   logic                     illegal;
   logic                     rdata_take;
   logic [DATA_WIDTH-1:0]    byte_rep;
   logic [DATA_WIDTH-1:0]    half_rep;
   logic [DATA_WIDTH-1:0]    store_wdata;
   logic [3:0]               store_be;
   logic [DATA_WIDTH-1:0]    rdata_shifted;
   logic [DATA_WIDTH-1:0]    load_fmt;

   // Request legality is judged on the live request so the decision is
   // made in the accept cycle.
   always_comb begin
      illegal = 1'b0;
      case (req_funct3)
         3'b000:         illegal = 1'b0;
         3'b001, 3'b101: illegal = req_addr[0] | (req_is_store & req_funct3[2]);
         3'b010:         illegal = |req_addr[1:0];
         3'b100:         illegal = req_is_store;
         default:        illegal = 1'b1;
      endcase
   end

   // Lane replication of store data: every byte lane carries the store byte,
   // every halfword lane carries the store halfword.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_byte_lane
         assign byte_rep[gi*8 +: 8] = wdata_reg[7:0];
      end
      for (gi = 0; gi < 2; gi++) begin : g_half_lane
         assign half_rep[gi*16 +: 16] = wdata_reg[15:0];
      end
   endgenerate

   always_comb begin
      case (funct3_reg[1:0])
         2'b00: begin
            store_be    = 4'b0001 << addr_reg[1:0];
            store_wdata = byte_rep;
         end
         2'b01: begin
            store_be    = addr_reg[1] ? 4'b1100 : 4'b0011;
            store_wdata = half_rep;
         end
         default: begin
            store_be    = 4'b1111;
            store_wdata = wdata_reg;
         end
      endcase
   end

   // Move the addressed byte/halfword down to bit 0, then extend.
   assign rdata_shifted = mem_rdata >> {addr_reg[1:0], 3'b000};

   always_comb begin
      case (funct3_reg)
         3'b000:  load_fmt = {{(DATA_WIDTH-8){rdata_shifted[7]}}, rdata_shifted[7:0]};
         3'b100:  load_fmt = {{(DATA_WIDTH-8){1'b0}}, rdata_shifted[7:0]};
         3'b001:  load_fmt = {{(DATA_WIDTH-16){rdata_shifted[15]}}, rdata_shifted[15:0]};
         3'b101:  load_fmt = {{(DATA_WIDTH-16){1'b0}}, rdata_shifted[15:0]};
         default: load_fmt = mem_rdata;
      endcase
   end

   // Next state and outputs. Data outputs are forced to zero outside the
   // state that presents them, so an idle (or freshly reset) unit shows
   // all-zero outputs apart from req_ready.
   always_comb begin
      state_next = state_reg;
      req_ready  = 1'b0;
      mem_valid  = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_be     = '0;
      WE3        = 1'b0;
      AD3        = '0;
      WD3        = '0;
      err        = 1'b0;
      rdata_take = 1'b0;
      case (state_reg)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_next = illegal ? ERR : REQ;
            end
         end
         ERR: begin
            err        = 1'b1;
            state_next = IDLE;
         end
         REQ: begin
            mem_valid = 1'b1;
            mem_we    = is_store_reg;
            mem_addr  = {addr_reg[DATA_WIDTH-1:2], 2'b00};
            mem_be    = is_store_reg ? store_be : 4'b1111;
            mem_wdata = is_store_reg ? store_wdata : '0;
            if (mem_ready) begin
               if (is_store_reg) begin
                  state_next = IDLE;
               end else if (mem_rvalid) begin
                  // Read data returned in the same cycle as the accept.
                  rdata_take = 1'b1;
                  state_next = WB;
               end else begin
                  state_next = WAIT;
               end
            end
         end
         WAIT: begin
            if (mem_rvalid) begin
               rdata_take = 1'b1;
               state_next = WB;
            end
         end
         WB: begin
            AD3        = rd_reg;
            WD3        = rdata_reg;
            WE3        = |rd_reg;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state_reg != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         is_store_reg <= 1'b0;
         funct3_reg   <= '0;
         addr_reg     <= '0;
         wdata_reg    <= '0;
         rd_reg       <= '0;
         rdata_reg    <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == IDLE && req_valid) begin
            is_store_reg <= req_is_store;
            funct3_reg   <= req_funct3;
            addr_reg     <= req_addr;
            wdata_reg    <= req_wdata;
            rd_reg       <= req_rd;
         end
         if (rdata_take) begin
            rdata_reg <= load_fmt;
         end
      end
   end

endmodule
